// File: rtl/mysystem_start_sequencer.sv
// Avalon-MM start sequencer: drives an engine through N start/done runs
// separated by G idle cycles, with done-wait timeout and abort.
// Ports: clk, reset_n (async active-low), address/chipselect/write_n/
//   writedata/readdata (Avalon-MM slave, zero wait states),
//   eng_start (1-cycle pulse out), eng_done (1-cycle pulse in), busy.
// Optional: define MYSYSTEM_START_SEQ_IRQ_EN to add the irq output and
//   the CTRL bit2 IRQ_EN enable.
module mysystem_start_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        eng_start,
    input  logic        eng_done,
    output logic        busy
`ifdef MYSYSTEM_START_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] runs_n;
    logic [CNT_W-1:0] gap_g;
    logic [CNT_W-1:0] runs_completed;
    logic [CNT_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             done_f;
    logic             aborted_f;
    logic             timeout_f;
    logic             irq_en;

    logic             wr;
    logic             wr_ctrl;
    logic             go_cmd;
    logic             abort_cmd;
    logic             timeout_hit;
    logic [CNT_W-1:0] rc_inc;
    logic             unused_wd;

    assign wr          = chipselect && !write_n;
    assign wr_ctrl     = wr && (address == 2'd0);
    assign go_cmd      = wr_ctrl && writedata[0] && !writedata[1];
    assign abort_cmd   = wr_ctrl && writedata[1];
    assign rc_inc      = runs_completed + 1'b1;
    assign busy        = (state != IDLE);
    assign unused_wd   = ^writedata;

    // Only meaningful in WAIT_DONE with no done this cycle; done wins
    // on the final cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !eng_done
                       && (to_cnt == TO_W'(TO_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            runs_n         <= '0;
            gap_g          <= '0;
            runs_completed <= '0;
            gap_cnt        <= '0;
            to_cnt         <= '0;
            done_f         <= 1'b0;
            aborted_f      <= 1'b0;
            timeout_f      <= 1'b0;
            irq_en         <= 1'b0;
            eng_start      <= 1'b0;
        end else begin
            eng_start <= 1'b0;

            // W1C first so that a status set in the same cycle wins.
            if (wr && address == 2'd3) begin
                if (writedata[1]) done_f    <= 1'b0;
                if (writedata[2]) aborted_f <= 1'b0;
                if (writedata[3]) timeout_f <= 1'b0;
            end

`ifdef MYSYSTEM_START_SEQ_IRQ_EN
            if (wr_ctrl) irq_en <= writedata[2];
`else
            irq_en <= 1'b0;
`endif

            if (state != IDLE && abort_cmd) begin
                state     <= IDLE;
                aborted_f <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr && address == 2'd1)
                            runs_n <= writedata[CNT_W-1:0];
                        if (wr && address == 2'd2)
                            gap_g <= writedata[CNT_W-1:0];
                        if (go_cmd && runs_n != '0) begin
                            runs_completed <= '0;
                            done_f         <= 1'b0;
                            aborted_f      <= 1'b0;
                            timeout_f      <= 1'b0;
                            state          <= START;
                            eng_start      <= 1'b1;
                        end
                    end
                    START: begin
                        state  <= WAIT_DONE;
                        to_cnt <= '0;
                    end
                    WAIT_DONE: begin
                        if (eng_done) begin
                            runs_completed <= rc_inc;
                            if (rc_inc == runs_n) begin
                                state  <= IDLE;
                                done_f <= 1'b1;
                            end else if (gap_g == '0) begin
                                state     <= START;
                                eng_start <= 1'b1;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= gap_g;
                            end
                        end else if (timeout_hit) begin
                            state     <= IDLE;
                            timeout_f <= 1'b1;
                            aborted_f <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        // G cycles in GAP, then START.
                        if (gap_cnt == CNT_W'(1)) begin
                            state     <= START;
                            eng_start <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MYSYSTEM_START_SEQ_IRQ_EN
    assign irq = irq_en && (done_f || aborted_f);
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[0] = busy;
                readdata[2] = irq_en;
            end
            2'd1: readdata[CNT_W-1:0] = runs_n;
            2'd2: readdata[CNT_W-1:0] = gap_g;
            default: begin
                readdata[0]          = busy;
                readdata[1]          = done_f;
                readdata[2]          = aborted_f;
                readdata[3]          = timeout_f;
                readdata[16 +: CNT_W] = runs_completed;
            end
        endcase
    end

endmodule
